// File: rtl/effects_chain_if.sv
// Sample and control bundle carried between the ADC front-end, effects_chain and
// the output serializer. The master modport drives samples and controls in.
interface effects_chain_if #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned GAIN_W   = 11
);
   logic                       valid_in;
   logic signed [SAMPLE_W-1:0] sample_in;
   logic [GAIN_W-1:0]          gain_target;
   logic                       drive_en;
   logic [7:0]                 volume;
   logic                       bypass;
   logic                       valid_out;
   logic signed [SAMPLE_W-1:0] sample_out;
   logic [GAIN_W-1:0]          gain_cur;
   logic                       ramp_busy;

   modport master (
      output valid_in, sample_in, gain_target, drive_en, volume, bypass,
      input  valid_out, sample_out, gain_cur, ramp_busy
   );

   modport slave (
      input  valid_in, sample_in, gain_target, drive_en, volume, bypass,
      output valid_out, sample_out, gain_cur, ramp_busy
   );
endinterface

// File: rtl/effects_chain.sv
// Three-stage guitar effects chain: capture, ramped gain with hard-clip overdrive,
// then output volume with saturation. Bypass returns the captured sample unchanged.
module effects_chain #(
   parameter int unsigned SAMPLE_W   = 16,
   parameter int unsigned GAIN_W     = 11,
   parameter int unsigned GAIN_FRAC  = 4,
   parameter int unsigned LEVEL_BITS = 12,
   parameter int unsigned RAMP_STEP  = 1
) (
   input logic            clk,
   input logic            rst,
   effects_chain_if.slave bus
);
   localparam int unsigned ProdW = SAMPLE_W + GAIN_W + 1;
   localparam int unsigned VolW  = SAMPLE_W + 9;

   localparam logic signed [ProdW-1:0] ClipPos = ProdW'((64'd1 << LEVEL_BITS) - 64'd1);
   localparam logic signed [ProdW-1:0] ClipNeg = -ClipPos;
   localparam logic signed [VolW-1:0]  SatPos  = VolW'((64'd1 << (SAMPLE_W - 1)) - 64'd1);
   localparam logic signed [VolW-1:0]  SatNeg  = ~SatPos;
   localparam logic [GAIN_W-1:0]       Step    = GAIN_W'(RAMP_STEP);

   typedef enum logic [1:0] {StIdle, StUp, StDown} ramp_state_e;

   ramp_state_e                state_q, state_d;
   logic [GAIN_W-1:0]          gain_q, gain_d, gain_diff;

   logic                       s1_valid_q, s1_drive_q, s1_bypass_q;
   logic signed [SAMPLE_W-1:0] s1_sample_q;
   logic [7:0]                 s1_volume_q;

   logic                       s2_valid_q, s2_bypass_q;
   logic signed [SAMPLE_W-1:0] s2_sample_q, s2_raw_q;
   logic [7:0]                 s2_volume_q;

   logic                       out_valid_q;
   logic signed [SAMPLE_W-1:0] out_sample_q;

   logic signed [ProdW-1:0]    drv_prod, drv_shift;
   logic signed [VolW-1:0]     vol_prod, vol_shift;
   logic signed [SAMPLE_W-1:0] s2_d, s3_d;

   // Direction is re-derived on every accepted sample so retargets never overshoot.
   always_comb begin
      state_d   = state_q;
      gain_d    = gain_q;
      gain_diff = '0;
      if (bus.valid_in) begin
         if (bus.gain_target > gain_q) begin
            gain_diff = bus.gain_target - gain_q;
            gain_d    = (gain_diff > Step) ? gain_q + Step : bus.gain_target;
            state_d   = (gain_diff > Step) ? StUp : StIdle;
         end else if (bus.gain_target < gain_q) begin
            gain_diff = gain_q - bus.gain_target;
            gain_d    = (gain_diff > Step) ? gain_q - Step : bus.gain_target;
            state_d   = (gain_diff > Step) ? StDown : StIdle;
         end else begin
            state_d = StIdle;
         end
      end
   end

   // gain_q here already carries the step taken on the edge that captured s1.
   always_comb begin
      drv_prod  = $signed({{(GAIN_W + 1){s1_sample_q[SAMPLE_W-1]}}, s1_sample_q})
                * $signed({{(SAMPLE_W + 1){1'b0}}, gain_q});
      drv_shift = drv_prod >>> GAIN_FRAC;
      s2_d      = s1_sample_q;
      if (s1_drive_q) begin
         if (drv_shift > ClipPos) begin
            s2_d = ClipPos[SAMPLE_W-1:0];
         end else if (drv_shift < ClipNeg) begin
            s2_d = ClipNeg[SAMPLE_W-1:0];
         end else begin
            s2_d = drv_shift[SAMPLE_W-1:0];
         end
      end
   end

   always_comb begin
      vol_prod  = $signed({{9{s2_sample_q[SAMPLE_W-1]}}, s2_sample_q})
                * $signed({{(SAMPLE_W + 1){1'b0}}, s2_volume_q});
      vol_shift = vol_prod >>> 7;
      if (s2_bypass_q) begin
         s3_d = s2_raw_q;
      end else if (vol_shift > SatPos) begin
         s3_d = SatPos[SAMPLE_W-1:0];
      end else if (vol_shift < SatNeg) begin
         s3_d = SatNeg[SAMPLE_W-1:0];
      end else begin
         s3_d = vol_shift[SAMPLE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         gain_q       <= '0;
         s1_valid_q   <= 1'b0;
         s1_sample_q  <= '0;
         s1_drive_q   <= 1'b0;
         s1_volume_q  <= '0;
         s1_bypass_q  <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_sample_q  <= '0;
         s2_raw_q     <= '0;
         s2_volume_q  <= '0;
         s2_bypass_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
      end else begin
         state_q    <= state_d;
         gain_q     <= gain_d;
         s1_valid_q <= bus.valid_in;
         if (bus.valid_in) begin
            s1_sample_q <= bus.sample_in;
            s1_drive_q  <= bus.drive_en;
            s1_volume_q <= bus.volume;
            s1_bypass_q <= bus.bypass;
         end
         s2_valid_q  <= s1_valid_q;
         s2_sample_q <= s2_d;
         s2_raw_q    <= s1_sample_q;
         s2_volume_q <= s1_volume_q;
         s2_bypass_q <= s1_bypass_q;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_sample_q <= s3_d;
         end
      end
   end

   assign bus.valid_out  = out_valid_q;
   assign bus.sample_out = out_sample_q;
   assign bus.gain_cur   = gain_q;
   assign bus.ramp_busy  = (state_q != StIdle) || (gain_q != bus.gain_target);
endmodule
